julia_escape_core: RTL and testbench
====================================

Name: julia_escape_core

Overview:
- Parametrised escape-time iterator for the Julia set visualizer.
- Accepts one pixel coordinate per job and iterates z <= z^2 + c at one step per clock.
- Returns the iteration count, an escaped flag, and a tag (pixel address) for the frame-buffer writer.
- Fixed-point width, iteration width and tag width are parameters. A runtime mode selects Julia (z0 = pixel, c = constant) or Mandelbrot (z0 = 0, c = pixel).

Parameters:
- W, 18: signed fixed-point width of z, c and pixel coordinates.
- FRAC, 14: fractional bits; 1.0 = 2^FRAC. W-FRAC must be >= 4, otherwise elaboration fails.
- ITER_W, 8: width of max_iter and out_iter.
- TAG_W, 17: width of the pass-through pixel tag.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- mode  in  1  0 = Julia, 1 = Mandelbrot; sampled at accept
- c_re, c_im  in  W each  Julia constant; sampled at accept
- max_iter  in  ITER_W  iteration limit; sampled at accept
- in_valid  in  1  job request
- in_ready  out  1  core can accept a job
- px_re, px_im  in  W each  pixel coordinate
- in_tag  in  TAG_W  pixel tag
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts the result
- out_iter  out  ITER_W  iteration count
- out_escaped  out  1  1 = escaped, 0 = hit the limit
- out_tag  out  TAG_W  tag of this result
- busy  out  1  high in ITER or DONE

Behaviour:
- Reset:
  - State goes to IDLE.
  - in_ready=1; out_valid=0; out_iter=0; out_escaped=0; out_tag=0; busy=0.
  - All internal z, c and count registers are cleared.
  - Reset during ITER or DONE discards the job; no partial result is ever emitted.
- FSM states IDLE, ITER, DONE:
  - in_ready is high only in IDLE.
  - IDLE: on in_valid & in_ready, the core latches mode, max_iter and in_tag.
    - Julia: z = px, c = c_in.
    - Mandelbrot: z = 0, c = px.
    - count = 0; go to ITER.
  - ITER: one evaluation per clock, in this priority order:
    - if |z|^2 > 4.0, go to DONE with escaped = 1 and out_iter = count;
    - else if count == max_iter, go to DONE with escaped = 0 and out_iter = max_iter;
    - else update z to (zr^2 - zi^2 + cr, 2*zr*zi + ci) and increment count.
  - DONE: out_valid = 1; out_iter, out_escaped and out_tag stay stable until out_ready. On out_valid & out_ready, go to IDLE.
  - A new job cannot be accepted in the same cycle as the result handshake.
- Latency: a job terminating at count n raises out_valid n+1 clocks after the accept edge.
- max_iter = 0: a single evaluation, so out_iter = 0 and escaped reflects z0.
- Inputs mode, c_re, c_im, max_iter, px_* and in_tag are ignored outside the accept cycle.
- Arithmetic:
  - Signed W x W products give 2W bits, arithmetic-shifted right by FRAC (floor).
  - Squares keep 2W-FRAC bits, with no integer truncation.
  - The escape compare uses the sum zr^2 + zi^2 at 2W-FRAC+1 bits against the constant 4 << FRAC, strict greater-than.
  - The cross term 2*zr*zi is the product shifted right by FRAC-1.
  - Next z is saturated to the W-bit signed range; it never wraps.
- The count never exceeds max_iter, so there is no count overflow.

Decomposition:
- Package julia_pkg holds:
  - the state enum (IDLE, ITER, DONE);
  - localparams ONE = 1 << FRAC and ESC_R2 = 4 << FRAC, derived per instance from FRAC;
  - a saturation function from a wide signed value to W bits.
- Sub-module julia_step is purely combinational:
  - inputs z, c;
  - outputs escape flag and next z (saturated);
  - it holds the three multipliers.
- julia_escape_core holds the FSM, registers and handshakes.

Test Plan (W=18, FRAC=14, 1.0=16384):
- Julia, c=(0,0), px=(0,0), max_iter=50 -> out_iter=50, escaped=0, out_valid 51 clocks after accept, out_tag echoed.
- Julia, c=(0,0), px=(49152,0) (3.0) -> out_iter=0, escaped=1, out_valid 1 clock after accept.
- Mandelbrot, px=(16384,0) (c=1.0), max_iter=255:
  - z runs 0, 1, 2, 5;
  - |2|^2 = 4 does not escape (strict compare);
  - expect out_iter=3, escaped=1.
- Julia, c=(-16384,0), px=(0,0), max_iter=255 -> z cycles 0, -1, 0; expect out_iter=255, escaped=0.
- Backpressure: hold out_ready=0 for 5 clocks in DONE while driving in_valid=1:
  - out_valid and all outputs stay stable; in_ready=0; no second job is accepted;
  - after the handshake, in_ready=1 the next cycle.
- Reset during ITER at count=10:
  - out_valid=0, in_ready=1, busy=0 immediately;
  - the next job completes with correct results and the aborted job's tag is never output.

Source files
------------

// File: rtl/julia_pkg.sv
`default_nettype none
// ============================================================================
// Module      : julia_pkg
// Description : Shared types and helpers for the Julia/Mandelbrot escape
//               iterator. It holds the FSM state enum, the fixed-point
//               constants (1.0 and the escape radius squared), and a
//               saturating narrow-to-W-bits helper.
// Revision    : 1.0  initial release
// ============================================================================
package julia_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Fixed-point constants depend on each instance's FRAC, so they are
  // provided as constant functions. Instances turn them into localparams.
  function automatic longint fx_one(input int frac);
    return longint'(1) << frac;
  endfunction

  function automatic longint fx_esc_r2(input int frac);
    return longint'(4) << frac;
  endfunction

  // Clamp a sign-extended wide value into the signed range of w bits.
  // The caller narrows the result to w bits.
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] x,
                                               input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

endpackage : julia_pkg
`default_nettype wire

// File: rtl/julia_escape_core_step.sv
`default_nettype none
// ============================================================================
// Module      : julia_step
// Description : One combinational Julia/Mandelbrot step. From z and c it
//               computes the escape test |z|^2 > 4.0 and the next value
//               z^2 + c, saturated to W bits.
// Ports       : zr, zi  in  W   current z (signed fixed point)
//               cr, ci  in  W   constant c
//               escape  out 1   |z|^2 strictly greater than 4.0
//               next_re out W   saturated real part of z^2 + c
//               next_im out W   saturated imaginary part of z^2 + c
// Revision    : 1.0  initial release
// ============================================================================
module julia_step
  import julia_pkg::*;
#(
  parameter int W    = 18,
  parameter int FRAC = 14
) (
  input  logic signed [W-1:0] zr,
  input  logic signed [W-1:0] zi,
  input  logic signed [W-1:0] cr,
  input  logic signed [W-1:0] ci,
  output logic                escape,
  output logic signed [W-1:0] next_re,
  output logic signed [W-1:0] next_im
);

  // A square scaled back by FRAC needs exactly 2W-FRAC signed bits. The
  // magnitude sum and the doubled cross term each need one more bit.
  localparam int SQ_W  = 2 * W - FRAC;
  localparam int MAG_W = SQ_W + 1;
  localparam int CR_W  = SQ_W + 1;
  localparam int IM_W  = CR_W + 1;
  localparam longint ESC_R2 = fx_esc_r2(FRAC);

  logic signed [2*W-1:0]  w_p_rr;
  logic signed [2*W-1:0]  w_p_ii;
  logic signed [2*W-1:0]  w_p_ri;
  logic signed [SQ_W-1:0] w_sq_r;
  logic signed [SQ_W-1:0] w_sq_i;
  logic signed [MAG_W-1:0] w_mag;
  logic signed [CR_W-1:0] w_cross;
  logic signed [MAG_W-1:0] w_re_wide;
  logic signed [IM_W-1:0] w_im_wide;

  assign w_p_rr = zr * zr;
  assign w_p_ii = zi * zi;
  assign w_p_ri = zr * zi;

  // The arithmetic shift floors the result. Only bits that repeat the
  // sign are dropped.
  assign w_sq_r  = SQ_W'(w_p_rr >>> FRAC);
  assign w_sq_i  = SQ_W'(w_p_ii >>> FRAC);
  // Shifting by FRAC-1 folds the factor of two into the scaling.
  assign w_cross = CR_W'(w_p_ri >>> (FRAC - 1));

  assign w_mag  = MAG_W'(w_sq_r) + MAG_W'(w_sq_i);
  assign escape = (w_mag > MAG_W'(ESC_R2));

  assign w_re_wide = MAG_W'(w_sq_r) - MAG_W'(w_sq_i) + MAG_W'(cr);
  assign w_im_wide = IM_W'(w_cross) + IM_W'(ci);

  assign next_re = W'(sat_w(64'(w_re_wide), W));
  assign next_im = W'(sat_w(64'(w_im_wide), W));

endmodule : julia_step
`default_nettype wire

// File: rtl/julia_escape_core.sv
`default_nettype none
// ============================================================================
// Module      : julia_escape_core
// Description : Escape-time iterator. It takes one pixel job, iterates
//               z <= z^2 + c once per clock, and returns the iteration count,
//               the escaped flag and the pixel tag. Mode selects the set:
//               Julia (z0 = pixel, c = c_in) or Mandelbrot (z0 = 0,
//               c = pixel).
// Ports       : clk, reset (async, active high)
//               mode, c_re, c_im, max_iter, px_re, px_im, in_tag : job
//                 inputs, sampled only on the accept cycle
//               in_valid / in_ready   : job handshake
//               out_valid / out_ready : result handshake
//               out_iter, out_escaped, out_tag : result, held while
//                 out_valid is high
//               busy : high while a job is iterating or waiting to be read
// Revision    : 1.0  initial release
// ============================================================================
module julia_escape_core
  import julia_pkg::*;
#(
  parameter int W      = 18,
  parameter int FRAC   = 14,
  parameter int ITER_W = 8,
  parameter int TAG_W  = 17
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mode,
  input  logic signed [W-1:0] c_re,
  input  logic signed [W-1:0] c_im,
  input  logic [ITER_W-1:0]   max_iter,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] px_re,
  input  logic signed [W-1:0] px_im,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ITER_W-1:0]   out_iter,
  output logic                out_escaped,
  output logic [TAG_W-1:0]    out_tag,
  output logic                busy
);

  // Reject parameter sets the fixed-point format cannot represent: there
  // must be room for values up to 8.0, and the wide intermediates must fit
  // the 64-bit helper.
  generate
    if ((W - FRAC) < 4) begin : g_bad_int_bits
      $error("julia_escape_core: W-FRAC must be at least 4");
    end
    if ((2 * W - FRAC + 2) > 64 || FRAC < 1) begin : g_bad_width
      $error("julia_escape_core: unsupported W/FRAC combination");
    end
  endgenerate

  state_t r_state;
  state_t w_next_state;

  logic signed [W-1:0] r_zr;
  logic signed [W-1:0] r_zi;
  logic signed [W-1:0] r_cr;
  logic signed [W-1:0] r_ci;
  logic [ITER_W-1:0]   r_count;
  logic [ITER_W-1:0]   r_max;
  logic [TAG_W-1:0]    r_tag;
  logic [ITER_W-1:0]   r_out_iter;
  logic                r_out_escaped;
  logic [TAG_W-1:0]    r_out_tag;

  logic                w_escape;
  logic signed [W-1:0] w_next_re;
  logic signed [W-1:0] w_next_im;
  logic                w_accept;
  logic                w_at_limit;

  julia_step #(
    .W    (W),
    .FRAC (FRAC)
  ) u_step (
    .zr      (r_zr),
    .zi      (r_zi),
    .cr      (r_cr),
    .ci      (r_ci),
    .escape  (w_escape),
    .next_re (w_next_re),
    .next_im (w_next_im)
  );

  assign w_at_limit = (r_count == r_max);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_next_state = ITER;
        end
      end
      ITER: begin
        busy = 1'b1;
        if (w_escape || w_at_limit) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        // Always return to IDLE, so a new job waits one cycle after the
        // result handshake.
        if (out_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Datapath: job capture, iteration and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_zr          <= '0;
      r_zi          <= '0;
      r_cr          <= '0;
      r_ci          <= '0;
      r_count       <= '0;
      r_max         <= '0;
      r_tag         <= '0;
      r_out_iter    <= '0;
      r_out_escaped <= 1'b0;
      r_out_tag     <= '0;
    end else if (w_accept) begin
      r_count <= '0;
      r_max   <= max_iter;
      r_tag   <= in_tag;
      if (mode) begin
        r_zr <= '0;
        r_zi <= '0;
        r_cr <= px_re;
        r_ci <= px_im;
      end else begin
        r_zr <= px_re;
        r_zi <= px_im;
        r_cr <= c_re;
        r_ci <= c_im;
      end
    end else if (r_state == ITER) begin
      // The escape test takes priority over the limit test.
      if (w_escape) begin
        r_out_iter    <= r_count;
        r_out_escaped <= 1'b1;
        r_out_tag     <= r_tag;
      end else if (w_at_limit) begin
        r_out_iter    <= r_max;
        r_out_escaped <= 1'b0;
        r_out_tag     <= r_tag;
      end else begin
        r_zr    <= w_next_re;
        r_zi    <= w_next_im;
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign out_iter    = r_out_iter;
  assign out_escaped = r_out_escaped;
  assign out_tag     = r_out_tag;

endmodule : julia_escape_core
`default_nettype wire

// File: tb/tb_julia_escape_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_julia_escape_core
// Description : Self-checking bench for julia_escape_core. Directed cases
//               and random jobs are compared against a plain-arithmetic
//               escape-time model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_julia_escape_core;

  localparam int W      = 18;
  localparam int FRAC   = 14;
  localparam int ITER_W = 8;
  localparam int TAG_W  = 17;
  localparam int BOUND  = 400;

  logic                clk = 1'b0;
  logic                reset;
  logic                mode;
  logic signed [W-1:0] c_re;
  logic signed [W-1:0] c_im;
  logic [ITER_W-1:0]   max_iter;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] px_re;
  logic signed [W-1:0] px_im;
  logic [TAG_W-1:0]    in_tag;
  logic                out_valid;
  logic                out_ready;
  logic [ITER_W-1:0]   out_iter;
  logic                out_escaped;
  logic [TAG_W-1:0]    out_tag;
  logic                busy;

  int checks = 0;
  int errors = 0;

  julia_escape_core #(
    .W      (W),
    .FRAC   (FRAC),
    .ITER_W (ITER_W),
    .TAG_W  (TAG_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mode        (mode),
    .c_re        (c_re),
    .c_im        (c_im),
    .max_iter    (max_iter),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .px_re       (px_re),
    .px_im       (px_im),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_iter    (out_iter),
    .out_escaped (out_escaped),
    .out_tag     (out_tag),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint sat_ref(input longint x);
    longint hi;
    longint lo;
    hi = (longint'(1) << (W - 1)) - 1;
    lo = -(longint'(1) << (W - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic void ref_model(input bit md, input int cre, input int cim,
                                    input int pr, input int pi, input int mx,
                                    output int it, output int esc);
    longint zr, zi, cr, ci, sr, si, tr;
    if (md) begin
      zr = 0; zi = 0; cr = pr; ci = pi;
    end else begin
      zr = pr; zi = pi; cr = cre; ci = cim;
    end
    it = mx;
    esc = 0;
    for (int k = 0; k <= mx; k++) begin
      sr = (zr * zr) >>> FRAC;
      si = (zi * zi) >>> FRAC;
      if (sr + si > (longint'(4) << FRAC)) begin
        it = k;
        esc = 1;
        return;
      end
      tr = sat_ref(sr - si + cr);
      zi = sat_ref(((zr * zi) >>> (FRAC - 1)) + ci);
      zr = tr;
    end
  endfunction

  task automatic drive_junk();
    mode     = 1'($urandom);
    c_re     = W'($urandom);
    c_im     = W'($urandom);
    max_iter = ITER_W'($urandom);
    px_re    = W'($urandom);
    px_im    = W'($urandom);
    in_tag   = TAG_W'($urandom);
  endtask

  // Runs one job end to end and compares it with the model. The result is
  // held for `hold` cycles before it is read; when `push` is set, in_valid
  // stays high during that hold.
  task automatic run_job(input string name, input bit md, input int cre,
                         input int cim, input int pr, input int pi,
                         input int mx, input int tg, input int hold,
                         input bit push, output int o_iter, output int o_esc,
                         output int o_tag, output int o_lat);
    int e_it, e_esc;
    ref_model(md, cre, cim, pr, pi, mx, e_it, e_esc);
    @(negedge clk);
    chk({name, "_in_ready_idle"}, in_ready, 1);
    mode = md; c_re = W'(cre); c_im = W'(cim); px_re = W'(pr); px_im = W'(pi);
    max_iter = ITER_W'(mx); in_tag = TAG_W'(tg); in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    o_lat = 0;
    for (int n = 0; n < BOUND; n++) begin
      @(posedge clk);
      o_lat++;
      @(negedge clk);
      in_valid = 1'b0;
      drive_junk();
      if (out_valid) break;
    end
    chk({name, "_out_valid_timeout"}, out_valid, 1);
    o_iter = int'(out_iter);
    o_esc  = int'(out_escaped);
    o_tag  = int'(out_tag);
    chk({name, "_iter_model"}, o_iter, e_it);
    chk({name, "_escaped_model"}, o_esc, e_esc);
    chk({name, "_tag"}, o_tag, tg & ((1 << TAG_W) - 1));
    chk({name, "_latency"}, o_lat, e_it + 1);
    for (int h = 0; h < hold; h++) begin
      in_valid = push;
      in_tag = TAG_W'(tg + 1);
      @(posedge clk);
      @(negedge clk);
      chk({name, "_hold_valid"}, out_valid, 1);
      chk({name, "_hold_iter"}, out_iter, o_iter);
      chk({name, "_hold_esc"}, out_escaped, o_esc);
      chk({name, "_hold_tag"}, out_tag, o_tag);
      chk({name, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({name, "_post_out_valid"}, out_valid, 0);
    chk({name, "_post_in_ready"}, in_ready, 1);
    chk({name, "_post_busy"}, busy, 0);
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  int it, es, tg, lat;

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    drive_junk();
    #12;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_iter", out_iter, 0);
    chk("reset_out_escaped", out_escaped, 0);
    chk("reset_out_tag", out_tag, 0);
    chk("reset_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;

    // Julia, z0 = c = 0: never escapes, runs to the limit.
    run_job("julia_zero", 1'b0, 0, 0, 0, 0, 50, 17'h1ABCD, 0, 1'b0, it, es, tg, lat);
    chk("julia_zero_iter", it, 50);
    chk("julia_zero_esc", es, 0);
    chk("julia_zero_lat", lat, 51);

    // z0 = 3.0 escapes on the first evaluation.
    run_job("julia_three", 1'b0, 0, 0, 49152, 0, 20, 17'h00123, 0, 1'b0, it, es, tg, lat);
    chk("julia_three_iter", it, 0);
    chk("julia_three_esc", es, 1);
    chk("julia_three_lat", lat, 1);

    // Mandelbrot, c = 1.0: |2|^2 == 4 does not escape.
    run_job("mandel_one", 1'b1, 0, 0, 16384, 0, 255, 17'h0BEEF, 0, 1'b0, it, es, tg, lat);
    chk("mandel_one_iter", it, 3);
    chk("mandel_one_esc", es, 1);

    // Julia, c = -1: period-2 orbit that stays bounded up to the full limit.
    run_job("julia_cyc", 1'b0, -16384, 0, 0, 0, 255, 17'h1FFFF, 0, 1'b0, it, es, tg, lat);
    chk("julia_cyc_iter", it, 255);
    chk("julia_cyc_esc", es, 0);

    // max_iter = 0 with a bounded z0 gives one evaluation and no escape.
    run_job("max_zero", 1'b0, 0, 0, 8192, 0, 0, 17'h00042, 0, 1'b0, it, es, tg, lat);
    chk("max_zero_iter", it, 0);
    chk("max_zero_esc", es, 0);

    // Next z saturates at the positive rail.
    run_job("saturate", 1'b0, 131071, 131071, 31130, 0, 30, 17'h00777, 0, 1'b0, it, es, tg, lat);
    chk("saturate_iter", it, 1);
    chk("saturate_esc", es, 1);

    // Backpressure with in_valid held high during DONE.
    run_job("backpressure", 1'b1, 0, 0, 16384, 0, 255, 17'h05555, 5, 1'b1, it, es, tg, lat);

    // Reset while iterating, at count 10.
    @(negedge clk);
    mode = 1'b0; c_re = '0; c_im = '0; px_re = '0; px_im = '0;
    max_iter = 8'd50; in_tag = 17'h0DEAD; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_out_tag", out_tag, 0);
    @(negedge clk);
    reset = 1'b0;
    run_job("after_abort", 1'b1, 0, 0, 16384, 0, 255, 17'h00ABC, 0, 1'b0, it, es, tg, lat);
    chk("after_abort_iter", it, 3);

    // Random jobs checked against the model.
    for (int r = 0; r < 24; r++) begin
      run_job("rand", 1'($urandom), int'($urandom_range(0, 32768)) - 16384,
              int'($urandom_range(0, 32768)) - 16384,
              int'($urandom_range(0, 65536)) - 32768,
              int'($urandom_range(0, 65536)) - 32768,
              int'($urandom_range(0, 60)), int'($urandom_range(0, 131071)),
              int'($urandom_range(0, 2)), 1'($urandom), it, es, tg, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Abort guard: the aborted job's tag must never appear as a result.
  always @(negedge clk) begin
    if (!reset && out_valid && out_tag == 17'h0DEAD) begin
      chk("aborted_tag_emitted", out_tag, -1);
    end
  end

endmodule : tb_julia_escape_core
`default_nettype wire
